// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the pipelined ARM-subset control unit: condition codes, data-processing
// commands, op classes, extend/register-source selects and the E-stage control word.
package arm_ctrl_pkg;

  // Condition field values (INSTR[31:28])
  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;
  localparam logic [3:0] CondNv = 4'b1111;

  // Data-processing commands; the value doubles as the ALU control code
  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdOrr = 4'b1100;
  localparam logic [3:0] CmdMov = 4'b1101;

  // Instruction classes (INSTR[27:26])
  localparam logic [1:0] OpDp  = 2'b00;
  localparam logic [1:0] OpMem = 2'b01;
  localparam logic [1:0] OpBr  = 2'b10;

  // Extend unit select
  localparam logic [1:0] ImmSrcDp  = 2'b00;
  localparam logic [1:0] ImmSrcMem = 2'b01;
  localparam logic [1:0] ImmSrcBr  = 2'b10;

  // Register-address mux select: bit 1 reads Rd on port 2, bit 0 reads PC on port 1
  localparam logic [1:0] RegSrcNone = 2'b00;
  localparam logic [1:0] RegSrcPc   = 2'b01;
  localparam logic [1:0] RegSrcRd   = 2'b10;

  // INSTR[27:4] of BX Rm
  localparam logic [23:0] BxPattern = 24'h12FFF1;

  // Control word carried from D into E
  typedef struct packed {
    logic [3:0] cond;
    logic       reg_write;
    logic       mem_write;
    logic       memtoreg;
    logic       branch;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic [1:0] flag_write;  // [1] = NZ, [0] = CV
  } ctrl_e_t;

  // Bubble: nothing written, condition AL so it behaves as a plain NOP
  localparam ctrl_e_t CtrlBubble = '{
    cond:       CondAl,
    reg_write:  1'b0,
    mem_write:  1'b0,
    memtoreg:   1'b0,
    branch:     1'b0,
    alu_ctrl:   4'b0000,
    alu_src:    1'b0,
    flag_write: 2'b00
  };

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Decode-side and pipeline-side control signals of the pipelined control unit.
interface pipelined_control_unit_if #(
  parameter int unsigned W      = 32,
  parameter int unsigned ALUC_W = 4
);

  logic [W-1:0]      INSTR_D;
  logic              FLUSH_E;
  logic              STALL_E;
  logic [3:0]        ALU_FLAGS_E;
  logic [1:0]        IMM_SRC_D;
  logic [1:0]        REG_SRC_D;
  logic              ILLEGAL_D;
  logic [ALUC_W-1:0] ALU_CTRL_E;
  logic              ALU_SRC_E;
  logic              BRANCH_TAKEN_E;
  logic              MEM_WRITE_M;
  logic              MEMTOREG_W;
  logic              REG_WRITE_W;
  logic              PC_SRC_W;
  logic [3:0]        FLAGS;

  // Fetch/hazard/datapath side
  modport master (
    output INSTR_D, FLUSH_E, STALL_E, ALU_FLAGS_E,
    input  IMM_SRC_D, REG_SRC_D, ILLEGAL_D, ALU_CTRL_E, ALU_SRC_E, BRANCH_TAKEN_E,
    input  MEM_WRITE_M, MEMTOREG_W, REG_WRITE_W, PC_SRC_W, FLAGS
  );

  // Control unit side
  modport slave (
    input  INSTR_D, FLUSH_E, STALL_E, ALU_FLAGS_E,
    output IMM_SRC_D, REG_SRC_D, ILLEGAL_D, ALU_CTRL_E, ALU_SRC_E, BRANCH_TAKEN_E,
    output MEM_WRITE_M, MEMTOREG_W, REG_WRITE_W, PC_SRC_W, FLAGS
  );

endinterface

// File: rtl/cond_unit.sv
// ARM condition evaluation for the instruction in E plus the architectural NZCV register.
// NZ and CV have separate write enables so logical ops with S set leave C and V alone.
module cond_unit
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_stall,
  input  logic [3:0] i_cond,
  input  logic [1:0] i_flag_write,
  input  logic [3:0] i_alu_flags,
  output logic       o_cond_ex,
  output logic [3:0] o_flags
);

  logic [3:0] r_flags;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;
  logic [1:0] w_flag_write_g;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Evaluate the E-stage condition field against the current flags
  always_comb begin
    o_cond_ex = 1'b0;
    unique case (i_cond)
      CondEq:  o_cond_ex = w_z;
      CondNe:  o_cond_ex = ~w_z;
      CondCs:  o_cond_ex = w_c;
      CondCc:  o_cond_ex = ~w_c;
      CondMi:  o_cond_ex = w_n;
      CondPl:  o_cond_ex = ~w_n;
      CondVs:  o_cond_ex = w_v;
      CondVc:  o_cond_ex = ~w_v;
      CondHi:  o_cond_ex = w_c & ~w_z;
      CondLs:  o_cond_ex = ~w_c | w_z;
      CondGe:  o_cond_ex = (w_n == w_v);
      CondLt:  o_cond_ex = (w_n != w_v);
      CondGt:  o_cond_ex = ~w_z & (w_n == w_v);
      CondLe:  o_cond_ex = w_z | (w_n != w_v);
      CondAl:  o_cond_ex = 1'b1;
      CondNv:  o_cond_ex = 1'b0;
      default: o_cond_ex = 1'b0;
    endcase
  end

  assign w_flag_write_g = i_flag_write & {2{o_cond_ex}};

  // NZCV register: split enables, frozen while E is stalled
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_flags <= FLAG_RST;
    end else if (!i_stall) begin
      if (w_flag_write_g[1]) r_flags[3:2] <= i_alu_flags[3:2];
      if (w_flag_write_g[0]) r_flags[1:0] <= i_alu_flags[1:0];
    end
  end

  assign o_flags = r_flags;

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit for the 32-bit ARM-subset core: decodes in D and carries the control
// word through E, M and W with condition-code gating, NZCV flags, flush bubbles and
// illegal-encoding detection. Fields come from fixed bit positions, so W must be at least 32.
// BL's link register (R14) is selected in the datapath; here BL only asserts RegWrite.
module pipelined_control_unit
  import arm_ctrl_pkg::*;
#(
  parameter int unsigned W        = 32,
  parameter int unsigned ALUC_W   = 4,
  parameter bit          EN_BX    = 1'b1,
  parameter logic [3:0]  FLAG_RST = 4'b0000
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  pipelined_control_unit_if.slave  bus
);

  logic [31:0] w_instr;
  logic [3:0]  w_cond;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic [3:0]  w_cmd;
  logic        w_s;
  logic        w_cmd_ok;
  logic        w_is_bx;
  logic        w_unused;

  ctrl_e_t     w_ctrl_d;
  logic [1:0]  w_imm_src;
  logic [1:0]  w_reg_src;
  logic        w_illegal;

  ctrl_e_t     r_ctrl_e;
  logic        w_cond_ex;
  logic        w_reg_write_g;
  logic        w_mem_write_g;
  logic        w_branch_g;

  logic        r_reg_write_m;
  logic        r_mem_write_m;
  logic        r_memtoreg_m;
  logic        r_pc_src_m;
  logic        r_reg_write_w;
  logic        r_memtoreg_w;
  logic        r_pc_src_w;

  assign w_instr  = bus.INSTR_D[31:0];
  assign w_cond   = w_instr[31:28];
  assign w_op     = w_instr[27:26];
  assign w_funct  = w_instr[25:20];
  assign w_cmd    = w_funct[4:1];
  assign w_s      = w_funct[0];
  assign w_is_bx  = EN_BX && (w_instr[27:4] == BxPattern);
  // Low nibble (BX Rm / shift operand) and any bits above 31 are datapath concerns
  assign w_unused = ^bus.INSTR_D;

  // CMP without S is not a real encoding in this subset
  assign w_cmd_ok = (w_cmd == CmdAnd) || (w_cmd == CmdSub) || (w_cmd == CmdAdd) ||
                    (w_cmd == CmdOrr) || (w_cmd == CmdMov) || ((w_cmd == CmdCmp) && w_s);

  // D-stage decode; anything unrecognised leaves the bubble word and raises ILLEGAL_D
  always_comb begin
    w_ctrl_d  = CtrlBubble;
    w_imm_src = ImmSrcDp;
    w_reg_src = RegSrcNone;
    w_illegal = 1'b0;
    if (w_is_bx) begin
      w_ctrl_d.cond     = w_cond;
      w_ctrl_d.branch   = 1'b1;
      w_ctrl_d.alu_ctrl = CmdMov;
    end else begin
      unique case (w_op)
        OpDp: begin
          if (w_cmd_ok) begin
            w_ctrl_d.cond          = w_cond;
            w_ctrl_d.reg_write     = (w_cmd != CmdCmp);
            w_ctrl_d.alu_ctrl      = w_cmd;
            w_ctrl_d.alu_src       = w_funct[5];
            w_ctrl_d.flag_write[1] = w_s;
            w_ctrl_d.flag_write[0] = w_s && ((w_cmd == CmdAdd) || (w_cmd == CmdSub) ||
                                             (w_cmd == CmdCmp));
            w_reg_src              = (w_cmd == CmdCmp) ? RegSrcRd : RegSrcNone;
          end else begin
            w_illegal = 1'b1;
          end
        end
        OpMem: begin
          if (!w_funct[5]) begin
            w_ctrl_d.cond     = w_cond;
            w_ctrl_d.alu_ctrl = CmdAdd;
            w_ctrl_d.alu_src  = 1'b1;
            w_imm_src         = ImmSrcMem;
            if (w_funct[0]) begin
              w_ctrl_d.reg_write = 1'b1;
              w_ctrl_d.memtoreg  = 1'b1;
            end else begin
              w_ctrl_d.mem_write = 1'b1;
              w_reg_src          = RegSrcRd;
            end
          end else begin
            w_illegal = 1'b1;
          end
        end
        OpBr: begin
          w_ctrl_d.cond      = w_cond;
          w_ctrl_d.branch    = 1'b1;
          w_ctrl_d.alu_ctrl  = CmdAdd;
          w_ctrl_d.alu_src   = 1'b1;
          w_ctrl_d.reg_write = w_funct[4];  // BL
          w_imm_src          = ImmSrcBr;
          w_reg_src          = RegSrcPc;
        end
        default: begin
          w_illegal = 1'b1;
        end
      endcase
    end
  end

  assign bus.IMM_SRC_D = w_imm_src;
  assign bus.REG_SRC_D = w_reg_src;
  assign bus.ILLEGAL_D = w_illegal;

  // D->E register: stall holds, flush or reset injects a bubble
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_ctrl_e <= CtrlBubble;
    end else if (!bus.STALL_E) begin
      r_ctrl_e <= bus.FLUSH_E ? CtrlBubble : w_ctrl_d;
    end
  end

  cond_unit #(
    .FLAG_RST (FLAG_RST)
  ) u_cond_unit (
    .i_clk        (CLK),
    .i_rst_n      (RESET_N),
    .i_stall      (bus.STALL_E),
    .i_cond       (r_ctrl_e.cond),
    .i_flag_write (r_ctrl_e.flag_write),
    .i_alu_flags  (bus.ALU_FLAGS_E),
    .o_cond_ex    (w_cond_ex),
    .o_flags      (bus.FLAGS)
  );

  assign w_reg_write_g = r_ctrl_e.reg_write & w_cond_ex;
  assign w_mem_write_g = r_ctrl_e.mem_write & w_cond_ex;
  assign w_branch_g    = r_ctrl_e.branch & w_cond_ex;

  assign bus.ALU_CTRL_E     = ALUC_W'(r_ctrl_e.alu_ctrl);
  assign bus.ALU_SRC_E      = r_ctrl_e.alu_src;
  assign bus.BRANCH_TAKEN_E = w_branch_g;

  // E->M register carries already-gated enables
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_reg_write_m <= 1'b0;
      r_mem_write_m <= 1'b0;
      r_memtoreg_m  <= 1'b0;
      r_pc_src_m    <= 1'b0;
    end else if (!bus.STALL_E) begin
      r_reg_write_m <= w_reg_write_g;
      r_mem_write_m <= w_mem_write_g;
      r_memtoreg_m  <= r_ctrl_e.memtoreg;
      r_pc_src_m    <= w_branch_g;
    end
  end

  // M->W register
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_reg_write_w <= 1'b0;
      r_memtoreg_w  <= 1'b0;
      r_pc_src_w    <= 1'b0;
    end else if (!bus.STALL_E) begin
      r_reg_write_w <= r_reg_write_m;
      r_memtoreg_w  <= r_memtoreg_m;
      r_pc_src_w    <= r_pc_src_m;
    end
  end

  assign bus.MEM_WRITE_M = r_mem_write_m;
  assign bus.MEMTOREG_W  = r_memtoreg_w;
  assign bus.REG_WRITE_W = r_reg_write_w;
  assign bus.PC_SRC_W    = r_pc_src_w;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: two instances (BX enabled / disabled) share the stimulus.
// An instruction-level model tracks what sits in E, M and W and checks every output each cycle.
module tb_pipelined_control_unit;

  localparam logic [31:0] Nop    = 32'hE1A00000;  // MOV R0,R0
  localparam logic [31:0] Adds   = 32'hE2911005;
  localparam logic [31:0] Cmp0   = 32'hE3500000;
  localparam logic [31:0] Beq    = 32'h0A000002;
  localparam logic [31:0] StrNe  = 32'h15812004;
  localparam logic [31:0] StrAl  = 32'hE5812004;
  localparam logic [31:0] Ldr    = 32'hE5912004;
  localparam logic [31:0] BxLr   = 32'hE12FFF1E;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = Nop;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  aluf = 4'b0000;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_control_unit_if #(.W(32), .ALUC_W(4)) bus0 ();
  pipelined_control_unit_if #(.W(32), .ALUC_W(4)) bus1 ();

  assign bus0.INSTR_D     = instr;
  assign bus0.FLUSH_E     = flush;
  assign bus0.STALL_E     = stall;
  assign bus0.ALU_FLAGS_E = aluf;
  assign bus1.INSTR_D     = instr;
  assign bus1.FLUSH_E     = flush;
  assign bus1.STALL_E     = stall;
  assign bus1.ALU_FLAGS_E = aluf;

  pipelined_control_unit #(
    .W(32), .ALUC_W(4), .EN_BX(1'b1), .FLAG_RST(4'b0000)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus0)
  );

  pipelined_control_unit #(
    .W(32), .ALUC_W(4), .EN_BX(1'b0), .FLAG_RST(4'b0000)
  ) dut_nbx (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus1)
  );

  // What an instruction asks for, straight from the instruction-set rules
  typedef struct packed {
    logic       legal, regw, memw, m2r, br, alusrc;
    logic [3:0] alu;
    logic       fnz, fcv;
    logic [1:0] imm, rsrc;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins, input bit en_bx);
    dec_t d;
    logic [3:0] cmd;
    logic s;
    d = '0;
    cmd = ins[24:21];
    s = ins[20];
    if (en_bx && ins[27:4] == 24'h12FFF1) begin
      d.legal = 1; d.br = 1; d.alu = 4'd13;
    end else if (ins[27:26] == 2'b00 && (cmd == 0 || cmd == 2 || cmd == 4 || cmd == 12 ||
                                          cmd == 13 || (cmd == 10 && s))) begin
      d.legal = 1; d.regw = (cmd != 10); d.alusrc = ins[25]; d.alu = cmd;
      d.fnz = s; d.fcv = s && (cmd == 2 || cmd == 4 || cmd == 10);
      d.rsrc = (cmd == 10) ? 2'b10 : 2'b00;
    end else if (ins[27:26] == 2'b01 && !ins[25]) begin
      d.legal = 1; d.alu = 4'd4; d.alusrc = 1; d.imm = 2'b01;
      if (ins[20]) begin d.regw = 1; d.m2r = 1; end
      else begin d.memw = 1; d.rsrc = 2'b10; end
    end else if (ins[27:26] == 2'b10) begin
      d.legal = 1; d.br = 1; d.alu = 4'd4; d.alusrc = 1; d.imm = 2'b10; d.rsrc = 2'b01;
      d.regw = ins[24];
    end
    return d;
  endfunction

  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Model state per instance: instruction held in E, gated enables in M and W, flags
  bit          e_valid [2];
  logic [31:0] e_ins   [2];
  bit          m_regw  [2];
  bit          m_memw  [2];
  bit          m_m2r   [2];
  bit          m_br    [2];
  bit          w_regw  [2];
  bit          w_m2r   [2];
  bit          w_pcs   [2];
  logic [3:0]  mflags  [2];

  function automatic dec_t dec_e(input int k);
    return decode(e_ins[k], k == 0);
  endfunction

  function automatic bit ce_e(input int k);
    return e_valid[k] && cond_true(e_ins[k][31:28], mflags[k]);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        e_valid[k] <= 0; e_ins[k] <= '0;
        m_regw[k] <= 0; m_memw[k] <= 0; m_m2r[k] <= 0; m_br[k] <= 0;
        w_regw[k] <= 0; w_m2r[k] <= 0; w_pcs[k] <= 0;
        mflags[k] <= 4'b0000;
      end else if (!stall) begin
        if (ce_e(k) && dec_e(k).fnz) mflags[k][3:2] <= aluf[3:2];
        if (ce_e(k) && dec_e(k).fcv) mflags[k][1:0] <= aluf[1:0];
        w_regw[k] <= m_regw[k];
        w_m2r[k]  <= m_m2r[k];
        w_pcs[k]  <= m_br[k];
        m_regw[k] <= ce_e(k) && dec_e(k).regw;
        m_memw[k] <= ce_e(k) && dec_e(k).memw;
        m_m2r[k]  <= e_valid[k] && dec_e(k).m2r;
        m_br[k]   <= ce_e(k) && dec_e(k).br;
        e_valid[k] <= !flush;
        e_ins[k]   <= instr;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0] imm, rsrc;
    logic       ill;
    logic [3:0] alu;
    logic       alusrc, brt, memw, m2r, regw, pcs;
    logic [3:0] flags;
  } obs_t;

  function automatic obs_t observe(input int k);
    obs_t o;
    if (k == 0)
      o = '{bus0.IMM_SRC_D, bus0.REG_SRC_D, bus0.ILLEGAL_D, bus0.ALU_CTRL_E, bus0.ALU_SRC_E,
            bus0.BRANCH_TAKEN_E, bus0.MEM_WRITE_M, bus0.MEMTOREG_W, bus0.REG_WRITE_W,
            bus0.PC_SRC_W, bus0.FLAGS};
    else
      o = '{bus1.IMM_SRC_D, bus1.REG_SRC_D, bus1.ILLEGAL_D, bus1.ALU_CTRL_E, bus1.ALU_SRC_E,
            bus1.BRANCH_TAKEN_E, bus1.MEM_WRITE_M, bus1.MEMTOREG_W, bus1.REG_WRITE_W,
            bus1.PC_SRC_W, bus1.FLAGS};
    return o;
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      obs_t o;
      dec_t dd;
      dec_t de;
      o  = observe(k);
      dd = decode(instr, k == 0);
      de = dec_e(k);
      check($sformatf("u%0d imm_src_d", k), 32'(o.imm), 32'(dd.imm));
      check($sformatf("u%0d reg_src_d", k), 32'(o.rsrc), 32'(dd.rsrc));
      check($sformatf("u%0d illegal_d", k), 32'(o.ill), 32'(!dd.legal));
      check($sformatf("u%0d alu_ctrl_e", k), 32'(o.alu), e_valid[k] ? 32'(de.alu) : 32'd0);
      check($sformatf("u%0d alu_src_e", k), 32'(o.alusrc), 32'(e_valid[k] && de.alusrc));
      check($sformatf("u%0d branch_taken_e", k), 32'(o.brt), 32'(ce_e(k) && de.br));
      check($sformatf("u%0d mem_write_m", k), 32'(o.memw), 32'(m_memw[k]));
      check($sformatf("u%0d memtoreg_w", k), 32'(o.m2r), 32'(w_m2r[k]));
      check($sformatf("u%0d reg_write_w", k), 32'(o.regw), 32'(w_regw[k]));
      check($sformatf("u%0d pc_src_w", k), 32'(o.pcs), 32'(w_pcs[k]));
      check($sformatf("u%0d flags", k), 32'(o.flags), 32'(mflags[k]));
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic f, input logic s, input logic r,
                       input logic [3:0] a);
    instr = i; flush = f; stall = s; rst_n = r; aluf = a;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  logic [31:0] dec_tab [10];
  logic [3:0]  ftab    [4];

  initial begin
    dec_tab = '{32'hE2511001, 32'hE1910002, 32'hE0010002, 32'hEB000010, 32'hEC000000,
                32'hE0210002, 32'hE1400000, 32'hE7912003, 32'h4A000004, 32'hE3A0100F};
    ftab = '{4'b0100, 4'b0010, 4'b1001, 4'b1000};

    // Reset
    drive(Nop, 0, 0, 0, 4'h0); cyc(); cyc();
    check("lit reset flags", bus0.FLAGS, 4'b0000);
    check("lit reset alu_ctrl_e", bus0.ALU_CTRL_E, 4'b0000);
    check("lit reset reg_write_w", bus0.REG_WRITE_W, 1'b0);

    // ADDS R1,R1,#5
    drive(Adds, 0, 0, 1, 4'h0); cyc();
    check("lit adds alu_ctrl_e", bus0.ALU_CTRL_E, 4'b0100);
    check("lit adds alu_src_e", bus0.ALU_SRC_E, 1'b1);
    drive(Nop, 0, 0, 1, 4'h0); cyc(); cyc();
    check("lit adds reg_write_w", bus0.REG_WRITE_W, 1'b1);
    check("lit adds flags", bus0.FLAGS, 4'b0000);

    // CMP / BEQ, Z set then Z clear
    for (int t = 0; t < 2; t++) begin
      drive(Cmp0, 0, 0, 1, 4'h0); cyc();
      drive(Beq, 0, 0, 1, (t == 0) ? 4'b0100 : 4'b0000); cyc();
      check("lit cmp flags", bus0.FLAGS, (t == 0) ? 4'b0100 : 4'b0000);
      check("lit beq taken", bus0.BRANCH_TAKEN_E, (t == 0) ? 1'b1 : 1'b0);
      drive(Nop, 0, 0, 1, 4'h0); cyc(); cyc();
      check("lit beq pc_src_w", bus0.PC_SRC_W, (t == 0) ? 1'b1 : 1'b0);
    end

    // STRNE squashed by Z, then an unconditional STR
    drive(Cmp0, 0, 0, 1, 4'h0); cyc();
    drive(StrNe, 0, 0, 1, 4'b0100); cyc();
    drive(Nop, 0, 0, 1, 4'h0); cyc();
    check("lit strne mem_write_m", bus0.MEM_WRITE_M, 1'b0);
    drive(StrAl, 0, 0, 1, 4'h0); cyc();
    drive(Nop, 0, 0, 1, 4'h0); cyc();
    check("lit str mem_write_m", bus0.MEM_WRITE_M, 1'b1);

    // LDR
    drive(Ldr, 0, 0, 1, 4'h0); cyc();
    drive(Nop, 0, 0, 1, 4'h0); cyc(); cyc();
    check("lit ldr memtoreg_w", bus0.MEMTOREG_W, 1'b1);
    check("lit ldr reg_write_w", bus0.REG_WRITE_W, 1'b1);

    // BX LR on both instances
    drive(BxLr, 0, 0, 1, 4'h0); cyc();
    check("lit bx illegal_d en", bus0.ILLEGAL_D, 1'b0);
    check("lit bx illegal_d dis", bus1.ILLEGAL_D, 1'b1);
    check("lit bx alu_ctrl_e", bus0.ALU_CTRL_E, 4'b1101);
    check("lit bx taken", bus0.BRANCH_TAKEN_E, 1'b1);
    check("lit bx dis taken", bus1.BRANCH_TAKEN_E, 1'b0);
    drive(Nop, 0, 0, 1, 4'h0); cyc(); cyc();
    check("lit bx pc_src_w", bus0.PC_SRC_W, 1'b1);
    check("lit bx dis pc_src_w", bus1.PC_SRC_W, 1'b0);

    // Flushed ADDS leaves no trace
    drive(Adds, 1, 0, 1, 4'h0); cyc();
    drive(Nop, 0, 0, 1, 4'hF); cyc(); cyc();
    check("lit flush reg_write_w", bus0.REG_WRITE_W, 1'b0);
    check("lit flush flags", bus0.FLAGS, 4'b0100);

    // Reset with a store in M
    drive(StrAl, 0, 0, 1, 4'h0); cyc();
    drive(Nop, 0, 0, 1, 4'h0); cyc();
    check("lit pre-reset mem_write_m", bus0.MEM_WRITE_M, 1'b1);
    drive(Nop, 0, 0, 0, 4'h0); cyc();
    check("lit reset mem_write_m", bus0.MEM_WRITE_M, 1'b0);
    check("lit reset flags again", bus0.FLAGS, 4'b0000);

    // Stall plus flush holds E and freezes the flags
    drive(Adds, 0, 0, 1, 4'h0); cyc();
    drive(Nop, 1, 1, 1, 4'hF); cyc();
    check("lit stall alu_ctrl_e", bus0.ALU_CTRL_E, 4'b0100);
    check("lit stall flags", bus0.FLAGS, 4'b0000);
    drive(Nop, 0, 0, 1, 4'b0110); cyc();
    check("lit unstall flags", bus0.FLAGS, 4'b0110);
    check("lit unstall alu_ctrl_e", bus0.ALU_CTRL_E, 4'b1101);

    // Every condition code against a few flag patterns
    for (int c = 0; c < 16; c++) begin
      for (int j = 0; j < 4; j++) begin
        logic [31:0] bcc;
        bcc = {4'(c), 28'hA000002};
        drive(Cmp0, 0, 0, 1, 4'h0); cyc();
        drive(bcc, 0, 0, 1, ftab[j]); cyc();
        drive(Nop, 0, 0, 1, 4'h0); cyc();
      end
    end

    // Mixed decode table, including illegal encodings, with varying ALU flags
    for (int i = 0; i < 10; i++) begin
      drive(dec_tab[i], (i == 6), (i == 3), 1, 4'(i * 5 + 3)); cyc();
    end
    drive(Nop, 0, 0, 1, 4'h0); cyc(); cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
